// File: rtl/dech_seq.sv
// Parametrised select decoder: registered one-hot output with enable hold-off stretch,
// stepped scan mode and wrap pulse. Define DECH_SEQ_ONEHOT_CHK_EN to add the sticky err checker.
module dech_seq #(
    parameter int SEL_W = 3,
    parameter int HOLD  = 2
) (
    input  logic                    clk,
    input  logic                    resetl,
    input  logic                    en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    load,
    input  logic                    step,
    input  logic                    dir,
    output logic [(1<<SEL_W)-1:0]   q,
    output logic [SEL_W-1:0]        cur,
    output logic                    active,
    output logic                    wrap
`ifdef DECH_SEQ_ONEHOT_CHK_EN
    ,
    output logic                    err
`endif
);

    localparam int OUT_N   = 1 << SEL_W;
    localparam int HOLD_M1 = (HOLD > 0) ? HOLD - 1 : 0;

    typedef enum logic [1:0] {S_OFF, S_ON, S_HOLD} state_t;

    state_t             state, state_next;
    logic [3:0]         hold_cnt, hold_cnt_next;
    logic [SEL_W-1:0]   idx, idx_next;
    logic               wrap_next;
    logic [OUT_N-1:0]   dec;

    // Index update; load beats step, and a step that crosses the end of the range flags wrap.
    always_comb begin
        idx_next  = idx;
        wrap_next = 1'b0;
        if (!mode || load) begin
            idx_next = sel;
        end else if (step) begin
            if (dir) begin
                idx_next  = idx - SEL_W'(1);
                wrap_next = (idx == '0);
            end else begin
                idx_next  = idx + SEL_W'(1);
                wrap_next = (idx == '1);
            end
        end
    end

    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        case (state)
            S_OFF: if (en) state_next = S_ON;
            S_ON: begin
                if (!en) begin
                    if (HOLD > 0) begin
                        state_next    = S_HOLD;
                        hold_cnt_next = 4'(HOLD_M1);
                    end else begin
                        state_next = S_OFF;
                    end
                end
            end
            S_HOLD: begin
                if (en)
                    state_next = S_ON;
                else if (hold_cnt == 4'd0)
                    state_next = S_OFF;
                else
                    hold_cnt_next = hold_cnt - 4'd1;
            end
            default: state_next = S_OFF;
        endcase
    end

    for (genvar i = 0; i < OUT_N; i++) begin : g_dec
        assign dec[i] = (idx_next == SEL_W'(i));
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state    <= S_OFF;
            hold_cnt <= 4'd0;
            idx      <= '0;
            q        <= '0;
            active   <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
            idx      <= idx_next;
            q        <= (state_next != S_OFF) ? dec : '0;
            active   <= (state_next != S_OFF);
            wrap     <= wrap_next;
        end
    end

    assign cur = idx;

`ifdef DECH_SEQ_ONEHOT_CHK_EN
    // Guards against upsets in the output register itself: more than one line, or active with none.
    logic multi_hot;
    assign multi_hot = |(q & (q - OUT_N'(1)));

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl)
            err <= 1'b0;
        else if (multi_hot || (active && (q == '0)))
            err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_dech_seq.sv
// Scoreboard bench for dech_seq: directed scenarios then random traffic against a
// cycle-level reference model; a separate monitor pops expectations and compares.
module tb_dech_seq;

    localparam int SEL_W = 3;
    localparam int HOLD  = 2;
    localparam int N     = 1 << SEL_W;

    logic             clk = 1'b0;
    logic             resetl = 1'b0;
    logic             en = 1'b0, mode = 1'b0, load = 1'b0, step = 1'b0, dir = 1'b0;
    logic [SEL_W-1:0] sel = '0;
    logic [N-1:0]     q;
    logic [SEL_W-1:0] cur;
    logic             active, wrap;
`ifdef DECH_SEQ_ONEHOT_CHK_EN
    logic             err;
`endif

    dech_seq #(.SEL_W(SEL_W), .HOLD(HOLD)) dut (
        .clk    (clk),
        .resetl (resetl),
        .en     (en),
        .mode   (mode),
        .sel    (sel),
        .load   (load),
        .step   (step),
        .dir    (dir),
        .q      (q),
        .cur    (cur),
        .active (active),
        .wrap   (wrap)
`ifdef DECH_SEQ_ONEHOT_CHK_EN
        ,
        .err    (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]     q;
        logic [SEL_W-1:0] cur;
        logic             active;
        logic             wrap;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_on = 1'b1;

    // Reference model: position in the index ring, and how many more cycles q stays lit after en drops.
    int   m_idx = 0;
    bit   m_lit = 1'b0;
    int   m_left = 0;

    task automatic check(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit e, input bit md, input int s,
                       input bit ld, input bit st, input bit d);
        exp_t x;
        bit   w;
        int   raw;
        @(negedge clk);
        resetl = r; en = e; mode = md; sel = SEL_W'(s); load = ld; step = st; dir = d;
        w = 1'b0;
        if (!r) begin
            m_idx = 0; m_lit = 1'b0; m_left = 0;
        end else begin
            if (!md || ld) begin
                m_idx = s;
            end else if (st) begin
                raw   = d ? m_idx - 1 : m_idx + 1;
                w     = (raw < 0) || (raw >= N);
                m_idx = (raw + N) % N;
            end
            if (e) begin
                m_lit  = 1'b1;
                m_left = HOLD;
            end else if (m_lit && m_left > 0) begin
                m_left--;
            end else begin
                m_lit = 1'b0;
            end
        end
        x.q      = m_lit ? N'(1 << m_idx) : '0;
        x.cur    = SEL_W'(m_idx);
        x.active = m_lit;
        x.wrap   = w;
        sb.push_back(x);
    endtask

    // Monitor: every edge produces a fresh output word.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on && sb.size() > 0) begin
                x = sb.pop_front();
                check("q", int'(q), int'(x.q));
                check("cur", int'(cur), int'(x.cur));
                check("active", int'(active), int'(x.active));
                check("wrap", int'(wrap), int'(x.wrap));
                check("onehot_width", int'($countones(q) <= 1), 1);
`ifdef DECH_SEQ_ONEHOT_CHK_EN
                check("err_quiet", int'(err), 0);
`endif
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t;
        #1;
        check("rst_q", int'(q), 0);
        check("rst_cur", int'(cur), 0);
        check("rst_active", int'(active), 0);
        check("rst_wrap", int'(wrap), 0);

        // reset, then direct decode
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 5, 0, 0, 0);
        // hold stretch, then re-raise during hold
        cyc(1, 1, 0, 3, 0, 0, 0);
        cyc(1, 0, 0, 3, 0, 0, 0);
        cyc(1, 0, 0, 3, 0, 0, 0);
        cyc(1, 0, 0, 3, 0, 0, 0);
        cyc(1, 1, 0, 3, 0, 0, 0);
        cyc(1, 0, 0, 3, 0, 0, 0);
        cyc(1, 1, 0, 3, 0, 0, 0);
        cyc(1, 1, 0, 3, 0, 0, 0);
        // scan up through the wrap
        cyc(1, 1, 1, 6, 1, 0, 0);
        cyc(1, 1, 1, 0, 0, 1, 0);
        cyc(1, 1, 1, 0, 0, 1, 0);
        cyc(1, 1, 1, 0, 0, 1, 0);
        // scan down from 0, then load+step together
        cyc(1, 1, 1, 0, 1, 0, 0);
        cyc(1, 1, 1, 0, 0, 1, 1);
        cyc(1, 1, 1, 2, 1, 1, 0);
        // step while in hold moves the lit line
        cyc(1, 0, 1, 0, 0, 1, 0);
        cyc(1, 0, 1, 0, 0, 1, 1);
        cyc(1, 0, 1, 0, 0, 0, 0);

        // asynchronous reset in the middle of hold
        cyc(1, 1, 0, 3, 0, 0, 0);
        cyc(1, 0, 0, 3, 0, 0, 0);
        @(posedge clk);
        #3;
        resetl = 1'b0;
        #1;
        check("async_q", int'(q), 0);
        check("async_active", int'(active), 0);
        check("async_cur", int'(cur), 0);
        check("async_wrap", int'(wrap), 0);
        cyc(0, 0, 0, 3, 0, 0, 0);
        cyc(1, 0, 0, 3, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 1, 1);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            cyc($urandom_range(0, 99) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                int'($urandom_range(0, N - 1)), $urandom_range(0, 5) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        t = 0;
        while (sb.size() > 0 && t < 10) begin
            @(posedge clk);
            #2;
            t++;
        end
        check("drain", sb.size(), 0);

`ifdef DECH_SEQ_ONEHOT_CHK_EN
        mon_on = 1'b0;
        @(negedge clk);
        force dut.q = N'(3);
        @(posedge clk);
        #1;
        check("err_set", int'(err), 1);
        @(negedge clk);
        release dut.q;
        resetl = 1'b1; en = 1'b1; mode = 1'b0; sel = SEL_W'(1);
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", int'(err), 1);
        resetl = 1'b0;
        #1;
        check("err_clear", int'(err), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dech_seq.md
Name: dech_seq

Overview:
- Parametrised successor to the fixed 3-to-8 select decoder.
- Takes an N-bit select and produces a registered 2^N-wide one-hot output.
- Adds three things the fixed decoder lacks: an enable with programmable hold-off stretch, a scan mode that walks the active line under a step strobe, and a wrap indication.
- Used for chip-select, bank-select and time-slot strobes in TOM/JERRY glue.

Parameters:
- SEL_W, 3, select width; OUT_N = 2^SEL_W outputs (SEL_W 1..6).
- HOLD, 2, cycles q stays asserted after en falls (0 = no stretch, max 15).

Ports:
- clk  in  1  system clock, all state on rising edge.
- resetl  in  1  asynchronous active-low reset.
- en  in  1  output enable request.
- mode  in  1  0 = direct decode, 1 = scan.
- sel  in  SEL_W  select value.
- load  in  1  scan mode: load sel into index.
- step  in  1  scan mode: advance index.
- dir  in  1  scan direction, 0 = up, 1 = down.
- q  out  OUT_N  registered one-hot output, all-zero when inactive.
- cur  out  SEL_W  current index register.
- active  out  1  q is currently driven (ON or HOLD state).
- wrap  out  1  one-cycle pulse when scan index wraps.

Behaviour:
- Reset (resetl low, asynchronous, immediate):
  - idx=0, state=OFF, hold_cnt=0.
  - q=0, cur=0, active=0, wrap=0.
- Index update (rising edge):
  - mode=0: idx<=sel every cycle; load, step and dir are ignored; wrap=0.
  - mode=1, priority load > step:
    - load=1: idx<=sel, wrap<=0.
    - else step=1: idx<=idx+1 (dir=0) or idx-1 (dir=1), modulo OUT_N.
    - wrap<=1 on the step edge where idx goes OUT_N-1->0 (up) or 0->OUT_N-1 (down), else 0.
    - else: idx holds, wrap<=0.
  - Simultaneous load and step: load wins, no wrap.
- Enable FSM (states OFF, ON, HOLD):
  - OFF: en=1 -> ON.
  - ON: en=0 and HOLD>0 -> HOLD with hold_cnt<=HOLD-1; en=0 and HOLD=0 -> OFF.
  - HOLD: en=1 -> ON; hold_cnt=0 -> OFF; else hold_cnt--.
- Output register:
  - q <= onehot(idx_next) when state_next is ON or HOLD, else 0.
  - q always follows the updated index: a step or load during HOLD moves the asserted line.
  - active <= (state_next != OFF).
  - cur <= idx_next.
- Latency: one cycle from en/sel/load/step sampled at edge k to q/cur/wrap valid after edge k.
- Width rule: q has exactly 0 or 1 bit set at all times.
- Reset mid-HOLD or mid-scan: all outputs clear immediately. After resetl rises, the first edge behaves as from OFF with idx=0.
- Changing mode mid-operation takes effect on the same edge. There is no extra state.

Optional Feature:
- Macro: DECH_SEQ_ONEHOT_CHK_EN.
- Defined:
  - Adds output port err (1 bit) and a registered checker.
  - err is set and sticky when the registered q has more than one bit set, or when active=1 with q=0 (SEU/logic guard).
  - err is cleared only by resetl.
- Undefined: no err port, no checker logic; behaviour is otherwise identical.

Test Plan (SEL_W=3, HOLD=2):
- Reset/direct decode: resetl low -> q=0x00, cur=0, active=0, wrap=0; release, mode=0, en=1, sel=5 -> after next edge q=0x20, cur=5, active=1.
- Hold stretch: ON with sel=3 (q=0x08), drop en -> q=0x08 for 2 more cycles (HOLD) then 0x00, active falls with q; re-raise en during HOLD -> stays 0x08, state ON.
- Scan up with wrap: mode=1, load sel=6, en=1, then step x3 dir=0 -> q 0x40, 0x80, 0x01, 0x02; wrap=1 only on the 7->0 cycle.
- Scan down and priority: idx=0, step dir=1 -> q=0x80, wrap=1; then load=1 and step=1 with sel=2 in the same cycle -> q=0x04, wrap=0.
- Async reset mid-HOLD: assert resetl low between edges during HOLD -> q=0 immediately; after release with en=0 -> q stays 0x00.
- With DECH_SEQ_ONEHOT_CHK_EN defined: force two q bits via testbench deposit -> err=1 next edge and sticky until resetl; normal runs of the above scenarios -> err stays 0.
